instr_decode_queue: RTL and testbench
=====================================

Name: instr_decode_queue

Overview:
- Parametrised successor to the combinational instruction decoder.
- Buffers fetched 16-bit instructions in a DEPTH-entry FIFO behind a valid/ready handshake and decodes the head entry.
- Presents opcode, op, shift, register numbers and sign-extended immediates to the controller FSM and datapath.
- Sits between instruction fetch/memory and the controller; the controller consumes the head via out_ready.

Parameters:
- DATA_W, 16, datapath width for sximm8/sximm5 outputs; must be ≥ 8.
- DEPTH, 2, queue entries; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear (branch redirect)
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  queue can accept this cycle
- in_instr  in  16  raw instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  controller consumes head this cycle
- nsel  in  3  one-hot register field select: 001 = Rm, 010 = Rd, 100 = Rn
- opcode  out  3  head[15:13]
- op  out  2  head[12:11]
- shift  out  2  head[4:3]
- readnum  out  3  selected register field
- writenum  out  3  selected register field (same as readnum)
- sximm8  out  DATA_W  sign-extended head[7:0]
- sximm5  out  DATA_W  sign-extended head[4:0]
- nsel_err  out  1  nsel not one of the legal codes while out_valid
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and count cleared to 0; out_valid = 0.
  - in_ready = 1 once reset is released.
  - All decoded outputs = 0; nsel_err = 0.
  - Storage contents are don't-care.
- Push: in_valid && in_ready at the clock edge writes in_instr at the write pointer.
- Pop: out_valid && out_ready at the clock edge advances the read pointer.
- Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH), registered-state only; no combinational dependence on out_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- No bypass: an instruction pushed at edge N is visible on outputs after edge N, i.e. one-cycle latency from acceptance.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pop when empty and push when full: ignored; no state change.
- flush = 1 at an edge:
  - count and pointers cleared to 0.
  - Overrides any push or pop in the same cycle; the pushed instruction is dropped.
  - in_ready is still driven as normal during the flush cycle.
- Decode (combinational from the head entry):
  - Field positions: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], shift[4:3], Rm[2:0].
  - sximm8 = {(DATA_W-8){head[7]}, head[7:0]}.
  - sximm5 = {(DATA_W-5){head[4]}, head[4:0]}.
  - readnum = writenum = Rm for nsel 001, Rd for 010, Rn for 100.
  - Any other nsel drives readnum = writenum = 0 and nsel_err = out_valid. No X output.
- When out_valid = 0, every decoded output is forced to 0, giving deterministic idle values.
- Reset asserted mid-operation discards the queue immediately. No partial-state recovery.

Decomposition:
- Package instr_pkg holds:
  - INSTR_W = 16.
  - Field-position localparams: OPCODE_HI/LO, OP_HI/LO, RN_HI/LO, RD_HI/LO, SH_HI/LO, RM_HI/LO.
  - NSEL_RM = 3'b001, NSEL_RD = 3'b010, NSEL_RN = 3'b100.
  - An opcode enum: MOV = 3'b110, ALU = 3'b101, LDR = 3'b011, STR = 3'b100.
- One sub-module, instr_field_decode:
  - Purely combinational; parametrised by DATA_W.
  - Takes the head instruction, nsel and valid; produces all decoded outputs and nsel_err.
- instr_decode_queue contains only the FIFO storage, pointers and count.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles, release → count = 0, out_valid = 0, in_ready = 1, all decoded outputs 0.
- Push 16'hD0FF, nsel = 100 → one cycle later:
  - out_valid = 1, opcode = 110, op = 10, readnum = 0.
  - sximm8 = 16'hFFFF, sximm5 = 16'hFFFF.
- Push 16'hA1A9, nsel stepped 001/010/100 → readnum = 1/5/1, shift = 01, opcode = 101, op = 00, sximm5 = 16'h0009.
- Full boundary: DEPTH = 2, push 3 instructions with out_ready = 0:
  - count = 2, in_ready = 0, third instruction not accepted.
  - Pop once → in_ready = 1 next cycle; entries emerge in FIFO order.
- Simultaneous push and pop at count = 1 → count stays 1, new head equals the pushed instruction. Flush with in_valid = 1 → count = 0, out_valid = 0, pushed instruction dropped.
- nsel = 011 with out_valid = 1 → readnum = writenum = 0, nsel_err = 1. Assert reset_n = 0 mid-stream → outputs zero asynchronously, before the next clock edge.

Source files
------------

// File: rtl/instr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_pkg: instruction widths, field positions, nsel codes, opcodes  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instr_pkg;

    localparam int INSTR_W   = 16;

    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 13;
    localparam int OP_HI     = 12;
    localparam int OP_LO     = 11;
    localparam int RN_HI     = 10;
    localparam int RN_LO     = 8;
    localparam int RD_HI     = 7;
    localparam int RD_LO     = 5;
    localparam int SH_HI     = 4;
    localparam int SH_LO     = 3;
    localparam int RM_HI     = 2;
    localparam int RM_LO     = 0;

    localparam logic [2:0] NSEL_RM = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RN = 3'b100;

    typedef enum logic [2:0] {
        MOV = 3'b110,
        ALU = 3'b101,
        LDR = 3'b011,
        STR = 3'b100
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_field_decode: combinational field split / sign-extension of    |
// | the queue head; all outputs forced to zero when the head is invalid  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_field_decode
    import instr_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [2:0]         nsel,
    input  logic               valid,
    output logic [2:0]         opcode,
    output logic [1:0]         op,
    output logic [1:0]         shift,
    output logic [2:0]         readnum,
    output logic [2:0]         writenum,
    output logic [DATA_W-1:0]  sximm8,
    output logic [DATA_W-1:0]  sximm5,
    output logic               nsel_err
);

    logic [2:0] w_regnum;
    logic       w_legal;

    always_comb begin
        w_regnum = '0;
        w_legal  = 1'b1;
        case (nsel)
            NSEL_RM: w_regnum = instr[RM_HI:RM_LO];
            NSEL_RD: w_regnum = instr[RD_HI:RD_LO];
            NSEL_RN: w_regnum = instr[RN_HI:RN_LO];
            default: w_legal  = 1'b0;
        endcase
    end

    assign opcode   = valid ? instr[OPCODE_HI:OPCODE_LO] : '0;
    assign op       = valid ? instr[OP_HI:OP_LO]         : '0;
    assign shift    = valid ? instr[SH_HI:SH_LO]         : '0;
    assign readnum  = valid ? w_regnum                   : '0;
    assign writenum = valid ? w_regnum                   : '0;
    // Size casts of signed operands replicate the sign bit up to DATA_W.
    assign sximm8   = valid ? DATA_W'($signed(instr[7:0])) : '0;
    assign sximm5   = valid ? DATA_W'($signed(instr[4:0])) : '0;
    assign nsel_err = valid && !w_legal;

endmodule
`default_nettype wire

// File: rtl/instr_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode_queue: DEPTH-entry instruction FIFO with decoded head   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_decode_queue
    import instr_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic [2:0]                 nsel,
    output logic [2:0]                 opcode,
    output logic [1:0]                 op,
    output logic [1:0]                 shift,
    output logic [2:0]                 readnum,
    output logic [2:0]                 writenum,
    output logic [DATA_W-1:0]          sximm8,
    output logic [DATA_W-1:0]          sximm5,
    output logic                       nsel_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // in_ready depends only on registered occupancy, so a full queue
    // refuses a push even when the head is being consumed that cycle.
    assign in_ready  = (r_count < c_depth);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= in_instr;
    end

    instr_field_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .instr    (r_mem[r_rd_ptr]),
        .nsel     (nsel),
        .valid    (out_valid),
        .opcode   (opcode),
        .op       (op),
        .shift    (shift),
        .readnum  (readnum),
        .writenum (writenum),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .nsel_err (nsel_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_decode_queue: directed stimulus with a popping scoreboard   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_decode_queue;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_instr;
    logic [2:0]  nsel, opcode, readnum, writenum;
    logic [1:0]  op, shift, count;
    logic [15:0] sximm8, sximm5;
    logic        nsel_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  opc;
        logic [1:0]  op;
        logic [1:0]  sh;
        logic [2:0]  rn;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    instr_decode_queue #(.DATA_W(16), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .nsel(nsel),
        .opcode(opcode), .op(op), .shift(shift),
        .readnum(readnum), .writenum(writenum),
        .sximm8(sximm8), .sximm5(sximm5),
        .nsel_err(nsel_err), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        sync();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
    endtask

    // Monitor: every head consumed by the controller must match the next
    // expected instruction (decoded with nsel = Rn at pop time).
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected_pop: got opcode %0h, expected no entry", opcode);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_opcode",   opcode,   e.opc);
                chk("sb_op",       op,       e.op);
                chk("sb_shift",    shift,    e.sh);
                chk("sb_readnum",  readnum,  e.rn);
                chk("sb_writenum", writenum, e.rn);
                chk("sb_sximm8",   sximm8,   e.sx8);
                chk("sb_sximm5",   sximm5,   e.sx5);
                chk("sb_nsel_err", nsel_err, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        out_ready = 1'b0; nsel = 3'b100;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_count",    count,     2'd0);
        chk("rst_outvalid", out_valid, 1'b0);
        chk("rst_inready",  in_ready,  1'b1);
        chk("rst_opcode",   opcode,    3'd0);
        chk("rst_readnum",  readnum,   3'd0);
        chk("rst_sximm8",   sximm8,    16'h0);
        chk("rst_sximm5",   sximm5,    16'h0);
        chk("rst_nselerr",  nsel_err,  1'b0);

        // Single instruction, one-cycle visibility
        sync();
        exp_q.push_back('{16'hD0FF, 3'b110, 2'b10, 2'b11, 3'd0, 16'hFFFF, 16'hFFFF});
        push(16'hD0FF);
        @(negedge clk);
        chk("d0ff_outvalid", out_valid, 1'b1);
        chk("d0ff_count",    count,     2'd1);
        sync();
        pop_one();

        // Register field selection on a held head
        exp_q.push_back('{16'hA1A9, 3'b101, 2'b00, 2'b01, 3'd1, 16'hFFA9, 16'h0009});
        push(16'hA1A9);
        nsel = 3'b001;
        @(negedge clk);
        chk("a1a9_rm_read",  readnum,  3'd1);
        chk("a1a9_rm_write", writenum, 3'd1);
        sync();
        nsel = 3'b010;
        @(negedge clk);
        chk("a1a9_rd_read",  readnum,  3'd5);
        sync();
        nsel = 3'b100;
        @(negedge clk);
        chk("a1a9_rn_read",  readnum,  3'd1);
        sync();
        pop_one();

        // Fill to DEPTH; third push refused, also while a pop happens
        exp_q.push_back('{16'h6123, 3'b011, 2'b00, 2'b00, 3'd1, 16'h0023, 16'h0003});
        exp_q.push_back('{16'h8456, 3'b100, 2'b00, 2'b10, 3'd4, 16'h0056, 16'hFFF6});
        in_valid = 1'b1;
        in_instr = 16'h6123; sync();
        in_instr = 16'h8456; sync();
        in_instr = 16'hC789; sync();
        @(negedge clk);
        chk("full_count",   count,    2'd2);
        chk("full_inready", in_ready, 1'b0);
        sync();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("after_pop_count",   count,    2'd1);
        chk("after_pop_inready", in_ready, 1'b1);

        // Simultaneous push and pop at count 1
        sync();
        exp_q.push_back('{16'h2A5F, 3'b001, 2'b01, 2'b11, 3'd2, 16'h005F, 16'hFFFF});
        in_valid = 1'b1; in_instr = 16'h2A5F; out_ready = 1'b1;
        sync();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("simul_count",    count,     2'd1);
        chk("simul_outvalid", out_valid, 1'b1);
        sync();
        pop_one();
        @(negedge clk);
        chk("drain_count", count, 2'd0);

        // Flush overrides a concurrent push
        sync();
        push(16'h1111);
        flush = 1'b1; in_valid = 1'b1; in_instr = 16'h2222;
        @(negedge clk);
        chk("flush_inready", in_ready, 1'b1);
        sync();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count",    count,     2'd0);
        chk("flush_outvalid", out_valid, 1'b0);
        chk("flush_opcode",   opcode,    3'd0);
        chk("flush_sximm8",   sximm8,    16'h0);
        sync();
        @(negedge clk);
        chk("flush_dropped", count, 2'd0);

        // Illegal nsel, then asynchronous reset mid-stream
        sync();
        push(16'hD0FF);
        nsel = 3'b011;
        @(negedge clk);
        chk("bad_nsel_read",  readnum,  3'd0);
        chk("bad_nsel_write", writenum, 3'd0);
        chk("bad_nsel_err",   nsel_err, 1'b1);
        chk("bad_nsel_valid", out_valid, 1'b1);
        sync();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_outvalid", out_valid, 1'b0);
        chk("async_rst_count",    count,     2'd0);
        chk("async_rst_nselerr",  nsel_err,  1'b0);
        chk("async_rst_opcode",   opcode,    3'd0);
        chk("async_rst_sximm8",   sximm8,    16'h0);
        sync();
        reset_n = 1'b1;
        nsel = 3'b100;
        @(negedge clk);
        chk("post_rst_count", count, 2'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
